// File: rtl/datapath_pkg.sv
// Shared types and default sizes for the execution datapath and its register file.
// Pure declarations: no latency, no flow control.
package datapath_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;

  typedef enum logic [1:0] {ADD  = 2'b00, SUB  = 2'b01, AND  = 2'b10, MVN  = 2'b11} alu_op_t;
  typedef enum logic [1:0] {PASS = 2'b00, LSL1 = 2'b01, LSR1 = 2'b10, ASR1 = 2'b11} shift_t;
  typedef enum logic [1:0] {
    VSEL_C     = 2'b00,
    VSEL_PC    = 2'b01,
    VSEL_IMM8  = 2'b10,
    VSEL_MDATA = 2'b11
  } vsel_t;

endpackage

// File: rtl/regfile.sv
// NREG x DW register file: combinational read, one write port; write visible one edge later.
// Always accepts writes; no backpressure.
module regfile
  import datapath_pkg::*;
#(
  parameter int W  = DW,
  parameter int N  = NREG,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write,
  input  logic [AW-1:0] writenum,
  input  logic [AW-1:0] readnum,
  input  logic [W-1:0]  data_in,
  output logic [W-1:0]  data_out
);

  logic [W-1:0] regs [N];

  // No write bypass: a same-index read during a write returns the old value.
  assign data_out = regs[readnum];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

endmodule

// File: rtl/simple_datapath.sv
// Execution datapath: register file, A/B operands, shifter, ALU, result C and {V,N,Z} status.
// One edge per stage (R->A/B->C->R); strobes are obeyed every cycle, no backpressure.
module simple_datapath
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    readnum,
  input  logic [2:0]    writenum,
  input  logic          write,
  input  logic [1:0]    vsel,
  input  logic          loada,
  input  logic          loadb,
  input  logic [1:0]    shift,
  input  logic          asel,
  input  logic          bsel,
  input  logic [1:0]    ALUop,
  input  logic          loadc,
  input  logic          loads,
  input  logic [DW-1:0] mdata,
  input  logic [DW-1:0] sximm8,
  input  logic [DW-1:0] sximm5,
  input  logic [7:0]    PC,
  output logic [DW-1:0] datapath_out,
  output logic [2:0]    Z_out
);

  logic [DW-1:0] data_in;
  logic [DW-1:0] rf_out;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] c_q;
  logic [2:0]    status_q;
  logic [DW-1:0] sh_out;
  logic [DW-1:0] ain;
  logic [DW-1:0] bin;
  logic [DW-1:0] alu_res;
  logic          alu_v;

  always_comb begin
    data_in = '0;
    case (vsel_t'(vsel))
      VSEL_C:     data_in = c_q;
      VSEL_PC:    data_in = {{(DW-8){1'b0}}, PC};
      VSEL_IMM8:  data_in = sximm8;
      VSEL_MDATA: data_in = mdata;
      default:    data_in = '0;
    endcase
  end

  regfile #(.W(DW), .N(NREG)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .writenum (writenum),
    .readnum  (readnum),
    .data_in  (data_in),
    .data_out (rf_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (loada) a_q <= rf_out;
      if (loadb) b_q <= rf_out;
    end
  end

  always_comb begin
    sh_out = b_q;
    case (shift_t'(shift))
      PASS:    sh_out = b_q;
      LSL1:    sh_out = {b_q[DW-2:0], 1'b0};
      LSR1:    sh_out = {1'b0, b_q[DW-1:1]};
      ASR1:    sh_out = {b_q[DW-1], b_q[DW-1:1]};
      default: sh_out = b_q;
    endcase
  end

  assign ain = asel ? '0 : a_q;
  assign bin = bsel ? sximm5 : sh_out;

  // Signed overflow: operands agree in sign (ADD) or differ (SUB), and the result sign flips.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (alu_op_t'(ALUop))
      ADD: begin
        alu_res = ain + bin;
        alu_v   = (ain[DW-1] == bin[DW-1]) && (alu_res[DW-1] != ain[DW-1]);
      end
      SUB: begin
        alu_res = ain - bin;
        alu_v   = (ain[DW-1] != bin[DW-1]) && (alu_res[DW-1] != ain[DW-1]);
      end
      AND:     alu_res = ain & bin;
      MVN:     alu_res = ~bin;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q      <= '0;
      status_q <= 3'b000;
    end else begin
      if (loadc) c_q      <= alu_res;
      if (loads) status_q <= {alu_v, alu_res[DW-1], (alu_res == '0)};
    end
  end

  assign datapath_out = c_q;
  assign Z_out        = status_q;

endmodule

// File: tb/tb_simple_datapath.sv
// Directed-vector bench for simple_datapath with hand-computed expectations.
module tb_simple_datapath;
  import datapath_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, asel, bsel, loadc, loads;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] mdata, sximm8, sximm5;
  logic [7:0]  PC;
  logic [15:0] datapath_out;
  logic [2:0]  Z_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  simple_datapath dut (
    .clk          (clk),
    .reset        (rst_n),
    .readnum      (readnum),
    .writenum     (writenum),
    .write        (write),
    .vsel         (vsel),
    .loada        (loada),
    .loadb        (loadb),
    .shift        (shift),
    .asel         (asel),
    .bsel         (bsel),
    .ALUop        (ALUop),
    .loadc        (loadc),
    .loads        (loads),
    .mdata        (mdata),
    .sximm8       (sximm8),
    .sximm5       (sximm5),
    .PC           (PC),
    .datapath_out (datapath_out),
    .Z_out        (Z_out)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    write = 0; loada = 0; loadb = 0; loadc = 0; loads = 0;
    asel = 0; bsel = 0; vsel = 2'b00; shift = 2'b00; ALUop = 2'b00;
    readnum = 0; writenum = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr_src(input logic [2:0] idx, input logic [1:0] src);
    writenum = idx; vsel = src; write = 1;
    tick();
  endtask

  task automatic wr_imm(input logic [2:0] idx, input logic [15:0] val);
    sximm8 = val;
    wr_src(idx, 2'b10);
  endtask

  task automatic load_a(input logic [2:0] idx);
    readnum = idx; loada = 1;
    tick();
  endtask

  task automatic load_b(input logic [2:0] idx);
    readnum = idx; loadb = 1;
    tick();
  endtask

  task automatic alu(input logic [1:0] sh, input logic as, input logic bs,
                     input logic [1:0] op, input logic lc, input logic ls);
    shift = sh; asel = as; bsel = bs; ALUop = op; loadc = lc; loads = ls;
    tick();
  endtask

  initial begin
    idle();
    mdata = 16'h0; sximm8 = 16'h0; sximm5 = 16'h0; PC = 8'h0;
    rst_n = 0;
    #1;
    check("reset_out", datapath_out, 16'h0000);
    check("reset_flags", {13'b0, Z_out}, 16'h0000);
    @(negedge clk);
    rst_n = 1;

    // 1: build up state, then reset mid-operation
    wr_imm(3, 16'h00AA);
    load_b(3);
    alu(2'b00, 1, 0, 2'b11, 1, 1);
    check("mvn_r3", datapath_out, 16'hFF55);
    check("mvn_r3_flags", {13'b0, Z_out}, 16'h0002);
    loadc = 1; loads = 1; write = 1; writenum = 3; vsel = 2'b10; sximm8 = 16'h1234;
    rst_n = 0;
    #1;
    check("rst_async_out", datapath_out, 16'h0000);
    check("rst_async_flags", {13'b0, Z_out}, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_hold_out", datapath_out, 16'h0000);
    @(negedge clk);
    rst_n = 1;
    idle();
    load_b(3);
    alu(2'b00, 1, 0, 2'b11, 1, 0);
    check("r3_cleared", datapath_out, 16'hFFFF);

    // 2: MOV immediate
    wr_imm(2, 16'hFFF9);
    load_b(2);
    alu(2'b00, 1, 0, 2'b00, 1, 0);
    check("mov_imm", datapath_out, 16'hFFF9);
    check("flags_held", {13'b0, Z_out}, 16'h0000);

    // 3: ADD with LSL1, write-back from C
    wr_imm(0, 16'd7);
    wr_imm(1, 16'd2);
    load_a(0);
    load_b(1);
    alu(2'b01, 0, 0, 2'b00, 1, 1);
    check("add_lsl", datapath_out, 16'd11);
    check("add_lsl_flags", {13'b0, Z_out}, 16'h0000);
    wr_src(2, 2'b00);
    load_b(2);
    alu(2'b00, 1, 0, 2'b11, 1, 0);
    check("wb_c_r2", datapath_out, 16'hFFF4);

    // 4: CMP with signed overflow, C untouched
    wr_imm(6, 16'h8000);
    wr_imm(7, 16'h0001);
    load_a(6);
    load_b(7);
    alu(2'b00, 0, 0, 2'b01, 0, 1);
    check("cmp_flags", {13'b0, Z_out}, 16'h0004);
    check("cmp_c_held", datapath_out, 16'hFFF4);

    // 5: ASR1 and MVN
    wr_imm(5, 16'h8004);
    load_b(5);
    alu(2'b11, 1, 0, 2'b00, 1, 1);
    check("asr1", datapath_out, 16'hC002);
    check("asr1_flags", {13'b0, Z_out}, 16'h0002);
    alu(2'b11, 1, 0, 2'b11, 1, 1);
    check("mvn_asr", datapath_out, 16'h3FFD);
    check("mvn_flags", {13'b0, Z_out}, 16'h0000);
    alu(2'b10, 1, 0, 2'b00, 1, 0);
    check("lsr1", datapath_out, 16'h4002);

    // AND of A=B=R5 loaded together, B shifted right: 8004 & 4002 = 0
    readnum = 5; loada = 1; loadb = 1;
    tick();
    alu(2'b10, 0, 0, 2'b10, 1, 1);
    check("and_zero", datapath_out, 16'h0000);
    check("and_flags", {13'b0, Z_out}, 16'h0001);
    alu(2'b01, 0, 0, 2'b10, 1, 1);
    check("and_lsl", datapath_out, 16'h0000);

    // 6: same-cycle read/write of R4 returns old value
    wr_imm(4, 16'd5);
    sximm8 = 16'd9; vsel = 2'b10; writenum = 4; write = 1; readnum = 4; loada = 1;
    tick();
    sximm5 = 16'h0000;
    alu(2'b00, 0, 1, 2'b00, 1, 0);
    check("rw_same_old", datapath_out, 16'd5);
    load_a(4);
    alu(2'b00, 0, 1, 2'b00, 1, 0);
    check("rw_same_new", datapath_out, 16'd9);
    sximm5 = 16'hFFFE;
    alu(2'b00, 0, 1, 2'b00, 1, 1);
    check("add_imm5", datapath_out, 16'd7);

    // PC and mdata write-back sources
    PC = 8'h5A;
    wr_src(1, 2'b01);
    load_b(1);
    alu(2'b00, 1, 0, 2'b00, 1, 0);
    check("wb_pc", datapath_out, 16'h005A);
    mdata = 16'hBEEF;
    wr_src(0, 2'b11);
    load_b(0);
    alu(2'b00, 1, 0, 2'b00, 1, 0);
    check("wb_mdata", datapath_out, 16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_datapath.md
Name: simple_datapath

Overview:
- Execution datapath directly downstream of the instruction-sequencing FSM controller.
- Consumes the controller's per-cycle control strobes: register read/write selects, operand loads, operand selects, write-back source, status load.
- Holds the 8-entry register file, the A/B operand registers, the shifter, the ALU, result register C and the status flags.
- Returns the result and flags to the controller and the top level.

Parameters:
- DW, 16, datapath word width in bits.
- NREG, 8, number of general registers; register index width is $clog2(NREG) = 3.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- readnum  in  3  register-file read index, combinational read.
- writenum  in  3  register-file write index.
- write  in  1  register-file write enable.
- vsel  in  2  write-back source: 00 = C, 01 = {8'b0,PC}, 10 = sximm8, 11 = mdata.
- loada  in  1  capture the register-file read value into A.
- loadb  in  1  capture the register-file read value into B.
- shift  in  2  shifter op: 00 pass, 01 LSL1, 10 LSR1, 11 ASR1.
- asel  in  1  1 = ALU A-input forced to 0, 0 = A.
- bsel  in  1  1 = ALU B-input sximm5, 0 = shifter output.
- ALUop  in  2  00 ADD, 01 SUB, 10 AND, 11 NOT B.
- loadc  in  1  capture the ALU result into C.
- loads  in  1  capture the ALU flags into status.
- mdata  in  DW  memory data for write-back.
- sximm8  in  DW  sign-extended 8-bit immediate.
- sximm5  in  DW  sign-extended 5-bit immediate.
- PC  in  8  program counter for write-back.
- datapath_out  out  DW  contents of C.
- Z_out  out  3  {V,N,Z} status register.

Behaviour:
Reset
- reset low clears asynchronously: all NREG registers, A, B, C, status.
- Outputs during and after reset: datapath_out = 0, Z_out = 3'b000.
- Reset asserted mid-operation discards every pending load or write. No state survives reset.

Register file
- Write: on a rising edge with write = 1, R[writenum] <= data_in (the vsel-selected source).
- Read: R[readnum] is combinational.
- Read and write of the same index in the same cycle: the read returns the old value (no bypass). The new value is visible the cycle after the edge.

Operand registers
- A <= R[readnum] on an edge with loada = 1.
- B <= R[readnum] on an edge with loadb = 1.
- loada and loadb both high: both registers capture the same value.
- Otherwise A and B hold their values.

Shifter (combinational, on B)
- LSL1: MSB dropped, 0 shifted in at LSB.
- LSR1: 0 shifted in at MSB.
- ASR1: B[DW-1] replicated into the MSB.

ALU (combinational)
- Ain = asel ? 0 : A. Bin = bsel ? sximm5 : shifter_out.
- ADD/SUB are modulo 2^DW.
- Z = (result == 0). N = result[DW-1].
- V for ADD = (Ain[15] == Bin[15]) && (res[15] != Ain[15]).
- V for SUB = (Ain[15] != Bin[15]) && (res[15] != Ain[15]).
- V for AND and NOT = 0.

Result and status
- C <= ALU result on an edge with loadc = 1.
- status <= {V,N,Z} on an edge with loads = 1.
- loadc and loads are independent: a compare loads status without touching C.

Latency
- Register to A/B: 1 edge.
- A/B to C: 1 edge.
- C to register file: 1 edge.
- A full ALU instruction therefore takes 4 edges including the A and B loads, matching the controller's GetA/GetB/op/Write sequence.
- MOV imm: a single edge with vsel = 10, write = 1.

Undefined inputs
- X on the select lines must not corrupt registers whose enable is 0.

Decomposition:
Shared package datapath_pkg:
- alu_op_t {ADD, SUB, AND, MVN}.
- shift_t {PASS, LSL1, LSR1, ASR1}.
- vsel_t {VSEL_C, VSEL_PC, VSEL_IMM8, VSEL_MDATA}.
- DW and NREG default constants.

Sub-modules:
- regfile: NREG x DW, async active-low reset, combinational read, write port.
- simple_datapath instantiates regfile. Shifter, ALU and the A/B/C/status registers stay inline.

Test Plan:
1. Reset low mid-run after writing R3 = 16'h00AA -> immediately datapath_out = 0, Z_out = 000. After release, reading R3 through A/C gives 0.
2. MOV imm: sximm8 = 16'hFFF9, vsel = 10, write = 1, writenum = 2. Then readnum = 2, loadb, shift = 00, asel = 1, ALUop = ADD, loadc -> datapath_out = 16'hFFF9.
3. ADD with shift: R0 = 7, R1 = 2. Load A = R0, B = R1, shift = LSL1, ALUop = ADD, loadc, loads -> C = 11, Z_out = 000. Write-back vsel = 00 to R2 -> R2 = 11.
4. CMP overflow: A = 16'h8000, B = 1, ALUop = SUB, loads only -> Z_out = {V=1,N=0,Z=0}, C unchanged from prior value.
5. MVN and ASR: B = 16'h8004, shift = ASR1 -> 16'hC002. ALUop = NOT -> C = 16'h3FFD, flags N = 0, Z = 0, V = 0.
6. Same-cycle read/write: R4 = 5. Write R4 = 9 while readnum = 4 with loada in the same edge -> A = 5. Next edge loada -> A = 9.
